lcd_quiz_ctrl: RTL and testbench

LCD_QUIZ_CTRL -- requirements
Module: lcd_quiz_ctrl

---
 rtl/lcd_quiz_pkg.sv | 58 +++++
 rtl/lcd_byte_writer.sv | 141 ++++++++++++++
 rtl/lcd_quiz_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_quiz_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_quiz_pkg.sv
// lcd_quiz_pkg: shared types and constants for the LCD quiz controller.
//   - quiz_state_e : top-level sequencer states
//   - wr_state_e   : byte-writer states (poll states used only with LCD_BUSY_POLL_EN)
//   - msg_e        : which banner is shown on line 1
//   - HD44780 command bytes and the line-1 / line-2 character ROM helpers
package lcd_quiz_pkg;

    typedef enum logic [1:0] {StInit, StIdle, StCheck, StDraw} quiz_state_e;

    typedef enum logic [2:0] {
        WrIdle, WrSetup, WrEn, WrHold, WrWait, WrPollSetup, WrPollEn, WrPollHold
    } wr_state_e;

    typedef enum logic [1:0] {MsgReady, MsgPass, MsgFail, MsgLocked} msg_e;

    // Wide enough for the default 100000-clock clear delay.
    localparam int unsigned DLY_W = 20;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [8*16-1:0] STR_READY  = "READY           ";
    localparam logic [8*16-1:0] STR_PASS   = "PASS            ";
    localparam logic [8*16-1:0] STR_FAIL   = "FAIL            ";
    localparam logic [8*16-1:0] STR_LOCKED = "LOCKED          ";
    localparam logic [8*6-1:0]  STR_TRIES  = "TRIES:";
    localparam logic [7:0]      CHR_SPACE  = 8'h20;
    localparam logic [7:0]      CHR_ZERO   = 8'h30;

    // Sequence indices of the final byte of each sequence.
    localparam logic [5:0] INIT_LAST = 6'd20;  // 4 cmds + 0x80 + 16 chars
    localparam logic [5:0] DRAW_LAST = 6'd33;  // 0x80 + 16 chars + 0xC0 + 16 chars

    function automatic logic [7:0] line1_char(msg_e m, logic [3:0] i);
        logic [8*16-1:0] s;
        case (m)
            MsgPass:   s = STR_PASS;
            MsgFail:   s = STR_FAIL;
            MsgLocked: s = STR_LOCKED;
            default:   s = STR_READY;
        endcase
        return s[8*(15 - int'(i)) +: 8];
    endfunction

    function automatic logic [7:0] line2_char(logic [3:0] tries, logic [3:0] i);
        if (i < 4'd6) begin
            return STR_TRIES[8*(5 - int'(i)) +: 8];
        end else if (i == 4'd6) begin
            return CHR_ZERO + {4'h0, tries};
        end
        return CHR_SPACE;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: writes one byte to an HD44780 and waits until it may take the next.
// Sequence: 1 setup clock (RS/DATA stable, EN low), EN high for EN_CYC clocks, 1 hold
// clock, then either i_delay idle clocks or (LCD_BUSY_POLL_EN defined) busy-flag reads
// repeated until DATA[7]=0 or i_timeout clocks have been spent polling.
// Ports:
//   iCLK, iRST_N   clock, synchronous active-low reset
//   i_abort        drop the current byte; EN low on the next clock
//   i_start        accepted when idle; latches i_rs, i_data, i_delay
//   i_bus_bf       LCD_DATA[7] as seen on the bus (busy flag)
//   i_timeout      poll timeout in clocks
//   o_done         one-clock pulse when the byte and its wait are complete
//   o_en/o_rs/o_rw LCD strobes; o_oe enables the data-bus driver; o_data bus value
module lcd_byte_writer
    import lcd_quiz_pkg::*;
#(
    parameter int unsigned EN_CYC = 16
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic             i_rs,
    input  logic [7:0]       i_data,
    input  logic [DLY_W-1:0] i_delay,
    input  logic             i_bus_bf,
    input  logic [DLY_W-1:0] i_timeout,
    output logic             o_done,
    output logic             o_en,
    output logic             o_rs,
    output logic             o_rw,
    output logic             o_oe,
    output logic [7:0]       o_data
);

    wr_state_e        r_state;
    wr_state_e        w_state_d;
    logic [DLY_W-1:0] r_cnt;
    logic             r_rs;
    logic [7:0]       r_data;
    logic [DLY_W-1:0] r_dly;
    logic             w_en_last;
    logic             w_wait_last;
    logic             w_poll_exit;
    logic             w_polling;

    assign w_en_last   = (r_cnt == DLY_W'(EN_CYC - 1));
    assign w_wait_last = ((r_cnt + DLY_W'(1)) >= r_dly);

`ifdef LCD_BUSY_POLL_EN
    logic [DLY_W-1:0] r_tmo;
    logic             r_bf;

    assign w_poll_exit = !r_bf || (r_tmo >= i_timeout);
    assign w_polling   = (r_state == WrPollSetup) || (r_state == WrPollEn) ||
                         (r_state == WrPollHold);

    // Timeout spans the whole poll phase, not a single read.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_tmo <= '0;
            r_bf  <= 1'b0;
        end else begin
            if (r_state == WrHold) begin
                r_tmo <= '0;
            end else if (w_polling && r_tmo != '1) begin
                r_tmo <= r_tmo + DLY_W'(1);
            end
            if (r_state == WrPollEn && w_en_last) begin
                r_bf <= i_bus_bf;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused    = ^{i_bus_bf, i_timeout};
    assign w_poll_exit = 1'b1;
    assign w_polling   = 1'b0;
`endif

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRST_N || i_abort) begin
            r_state <= WrIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            WrIdle:  if (i_start) w_state_d = WrSetup;
            WrSetup: w_state_d = WrEn;
            WrEn:    if (w_en_last) w_state_d = WrHold;
`ifdef LCD_BUSY_POLL_EN
            WrHold:      w_state_d = WrPollSetup;
            WrPollSetup: w_state_d = WrPollEn;
            WrPollEn:    if (w_en_last) w_state_d = WrPollHold;
            WrPollHold:  w_state_d = w_poll_exit ? WrIdle : WrPollSetup;
`else
            WrHold:  w_state_d = WrWait;
`endif
            WrWait:  if (w_wait_last) w_state_d = WrIdle;
            default: w_state_d = WrIdle;
        endcase
    end

    // Per-state cycle counter and latched byte
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_cnt  <= '0;
            r_rs   <= 1'b0;
            r_data <= 8'h00;
            r_dly  <= '0;
        end else begin
            if (i_abort || w_state_d != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + DLY_W'(1);
            end
            if (r_state == WrIdle && i_start && !i_abort) begin
                r_rs   <= i_rs;
                r_data <= i_data;
                r_dly  <= i_delay;
            end
        end
    end

    // Outputs
    always_comb begin
        o_en   = (r_state == WrEn) || (r_state == WrPollEn);
        o_done = ((r_state == WrWait) && w_wait_last) ||
                 ((r_state == WrPollHold) && w_poll_exit);
        o_rw   = w_polling;
        o_rs   = w_polling ? 1'b0 : r_rs;
        o_oe   = !w_polling;
        o_data = r_data;
    end

endmodule

// File: rtl/lcd_quiz_ctrl.sv
// lcd_quiz_ctrl: answer-check quiz that reports its verdict on an HD44780 16x2 LCD.
// Initialises the LCD and shows "READY"; each accepted submit rising edge compares the
// answer with KEY, updates the verdict LEDs / try counter / lockout and redraws both lines.
// Optional feature macro: LCD_BUSY_POLL_EN (busy-flag polling inside lcd_byte_writer).
// Ports:
//   iCLK, iRST_N   clock, synchronous active-low reset
//   answer         candidate answer, sampled when a submit is accepted
//   submit         asynchronous level; each rising edge is one submit request
//   rst            soft clear, active-high level
//   LCD_DATA       HD44780 data bus (released only while polling the busy flag)
//   LCD_RW/EN/RS   HD44780 control strobes
//   greenOut       last verdict correct; redOut last verdict wrong or locked
//   locked         lockout active; busy LCD sequence in progress
module lcd_quiz_ctrl
    import lcd_quiz_pkg::*;
#(
    parameter int unsigned       ANS_W     = 10,
    parameter logic [ANS_W-1:0]  KEY       = ANS_W'(10'h2A5),
    parameter int unsigned       MAX_TRIES = 3,
    parameter int unsigned       EN_CYC    = 16,
    parameter int unsigned       CMD_DLY   = 2500,
    parameter int unsigned       CLR_DLY   = 100000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [ANS_W-1:0] answer,
    input  logic             submit,
    input  logic             rst,
    inout  wire  [7:0]       LCD_DATA,
    output logic             LCD_RW,
    output logic             LCD_EN,
    output logic             LCD_RS,
    output logic             greenOut,
    output logic             redOut,
    output logic             locked,
    output logic             busy
);

    quiz_state_e      r_state;
    quiz_state_e      w_state_d;
    logic [5:0]       r_idx;
    logic             r_issued;
    logic [DLY_W-1:0] r_pwr_cnt;
    logic             r_sub_s1;
    logic             r_sub_s2;
    logic             r_sub_prev;
    logic [ANS_W-1:0] r_ans;
    logic [3:0]       r_tries;
    logic             r_locked;
    logic             r_green;
    logic             r_red;
    msg_e             r_msg;

    logic             w_sub_edge;
    logic             w_accept;
    logic             w_pwr_done;
    logic             w_last;
    logic             w_start;
    logic             w_done;
    logic             w_rs;
    logic [7:0]       w_byte;
    logic [DLY_W-1:0] w_delay;
    logic             w_oe;
    logic [7:0]       w_data;

    assign w_sub_edge = r_sub_s2 & ~r_sub_prev;
    assign w_accept   = (r_state == StIdle) && w_sub_edge && !r_locked && !rst;
    assign w_pwr_done = (r_pwr_cnt >= DLY_W'(CLR_DLY));
    assign w_last     = (r_state == StInit) ? (r_idx == INIT_LAST) : (r_idx == DRAW_LAST);

    // Submit synchroniser; keeps running through soft clear so no stale edge is seen later.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_sub_s1   <= 1'b0;
            r_sub_s2   <= 1'b0;
            r_sub_prev <= 1'b0;
        end else begin
            r_sub_s1   <= submit;
            r_sub_s2   <= r_sub_s1;
            r_sub_prev <= r_sub_s2;
        end
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRST_N || rst) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StInit:  if (w_done && w_last) w_state_d = StIdle;
            StIdle:  if (w_accept) w_state_d = StCheck;
            StCheck: w_state_d = StDraw;
            StDraw:  if (w_done && w_last) w_state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (r_state != StIdle);
        w_start  = !r_issued && (((r_state == StInit) && w_pwr_done) || (r_state == StDraw));
        greenOut = r_green;
        redOut   = r_red;
        locked   = r_locked;
    end

    // Byte ROM: which byte the sequence index selects in the current state
    always_comb begin
        w_rs   = 1'b0;
        w_byte = 8'h00;
        if (r_state == StInit) begin
            case (r_idx)
                6'd0:    w_byte = CMD_FUNC_SET;
                6'd1:    w_byte = CMD_DISP_ON;
                6'd2:    w_byte = CMD_CLEAR;
                6'd3:    w_byte = CMD_ENTRY;
                6'd4:    w_byte = CMD_LINE1;
                default: begin
                    w_rs   = 1'b1;
                    w_byte = line1_char(MsgReady, 4'(r_idx - 6'd5));
                end
            endcase
        end else begin
            if (r_idx == 6'd0) begin
                w_byte = CMD_LINE1;
            end else if (r_idx <= 6'd16) begin
                w_rs   = 1'b1;
                w_byte = line1_char(r_msg, 4'(r_idx - 6'd1));
            end else if (r_idx == 6'd17) begin
                w_byte = CMD_LINE2;
            end else begin
                w_rs   = 1'b1;
                w_byte = line2_char(r_tries, 4'(r_idx - 6'd18));
            end
        end
        w_delay = (!w_rs && w_byte == CMD_CLEAR) ? DLY_W'(CLR_DLY) : DLY_W'(CMD_DLY);
    end

    // Sequencing, verdict and try bookkeeping
    always_ff @(posedge iCLK) begin
        if (!iRST_N || rst) begin
            r_idx     <= '0;
            r_issued  <= 1'b0;
            r_pwr_cnt <= '0;
            r_ans     <= '0;
            r_tries   <= '0;
            r_locked  <= 1'b0;
            r_green   <= 1'b0;
            r_red     <= 1'b0;
            r_msg     <= MsgReady;
        end else begin
            if (w_done) begin
                r_issued <= 1'b0;
                r_idx    <= w_last ? 6'd0 : r_idx + 6'd1;
            end else if (w_start) begin
                r_issued <= 1'b1;
            end
            if (r_state == StInit && !w_pwr_done) begin
                r_pwr_cnt <= r_pwr_cnt + DLY_W'(1);
            end
            if (w_accept) begin
                r_ans <= answer;
            end
            if (r_state == StCheck) begin
                if (r_ans == KEY) begin
                    r_green <= 1'b1;
                    r_red   <= 1'b0;
                    r_msg   <= MsgPass;
                end else begin
                    r_green <= 1'b0;
                    r_red   <= 1'b1;
                    if (r_tries < 4'(MAX_TRIES)) begin
                        r_tries <= r_tries + 4'd1;
                    end
                    if ((r_tries + 4'd1) >= 4'(MAX_TRIES)) begin
                        r_locked <= 1'b1;
                        r_msg    <= MsgLocked;
                    end else begin
                        r_msg    <= MsgFail;
                    end
                end
            end
        end
    end

    lcd_byte_writer #(
        .EN_CYC (EN_CYC)
    ) u_writer (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .i_abort   (rst),
        .i_start   (w_start),
        .i_rs      (w_rs),
        .i_data    (w_byte),
        .i_delay   (w_delay),
        .i_bus_bf  (LCD_DATA[7]),
        .i_timeout (DLY_W'(CLR_DLY)),
        .o_done    (w_done),
        .o_en      (LCD_EN),
        .o_rs      (LCD_RS),
        .o_rw      (LCD_RW),
        .o_oe      (w_oe),
        .o_data    (w_data)
    );

    assign LCD_DATA = w_oe ? w_data : 8'hzz;

endmodule

// File: tb/tb_lcd_quiz_ctrl.sv
// Scoreboard bench for lcd_quiz_ctrl: expected LCD bytes are queued from a screen-level
// model when stimulus is issued; a negedge monitor decodes each write strobe and compares.
module tb_lcd_quiz_ctrl;
    localparam int unsigned ANS_W     = 10;
    localparam logic [9:0]  KEY       = 10'h2A5;
    localparam int          MAX_TRIES = 3;
    localparam int          EN_CYC    = 2;
    localparam int          CMD_DLY   = 4;
    localparam int          CLR_DLY   = 8;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic [9:0] answer = '0;
    logic       submit = 1'b0;
    logic       rst    = 1'b0;
    wire  [7:0] lcd_data;
    logic       lcd_rw, lcd_en, lcd_rs, green, red, locked, busy;

    always #5 iCLK = ~iCLK;

    lcd_quiz_ctrl #(
        .ANS_W(ANS_W), .KEY(KEY), .MAX_TRIES(MAX_TRIES),
        .EN_CYC(EN_CYC), .CMD_DLY(CMD_DLY), .CLR_DLY(CLR_DLY)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .answer(answer), .submit(submit), .rst(rst),
        .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en), .LCD_RS(lcd_rs),
        .greenOut(green), .redOut(red), .locked(locked), .busy(busy)
    );

`ifdef LCD_BUSY_POLL_EN
    int poll_left = 3;
    assign lcd_data = lcd_rw ? {(poll_left > 0), 7'h00} : 8'hzz;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    // Model state
    int m_tries  = 0;
    bit m_locked = 0;
    bit m_green  = 0;
    bit m_red    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic string pad16(input string s);
        string r = s;
        while (r.len() < 16) r = {r, " "};
        return r;
    endfunction

    function automatic void push_cmd(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endfunction

    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
    endfunction

    function automatic void push_init();
        push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h01); push_cmd(8'h06);
        push_cmd(8'h80); push_str(pad16("READY"));
    endfunction

    function automatic void push_draw(input string msg);
        push_cmd(8'h80); push_str(pad16(msg));
        push_cmd(8'hC0); push_str(pad16($sformatf("TRIES:%0d", m_tries)));
    endfunction

    // Monitor: decodes write strobes, checks EN width and setup, pops the scoreboard.
    int         en_rises = 0;
    int         en_w     = 0;
    bit         en_prev  = 0;
    bit         ignore_fall = 0;
    logic       prev_rs  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge iCLK) begin
        logic [8:0] e;
        if (lcd_en === 1'b1 && !en_prev) begin
            en_rises++;
            en_w = 1;
            if (lcd_rw === 1'b0) check("setup_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
        end else if (lcd_en === 1'b1) begin
            en_w++;
        end
        if (lcd_en === 1'b0 && en_prev) begin
            if (lcd_rw === 1'b1) begin
`ifdef LCD_BUSY_POLL_EN
                if (poll_left > 0) poll_left--;
`endif
            end else if (ignore_fall) begin
                ignore_fall = 0;
            end else begin
                check("en_width", en_w, EN_CYC);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", {lcd_rs, lcd_data});
                end else begin
                    e = exp_q.pop_front();
                    check("lcd_byte", {lcd_rs, lcd_data}, e);
                end
            end
        end
        en_prev   = (lcd_en === 1'b1);
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_busy(input logic v, input int budget, input string nm);
        int n = 0;
        while (busy !== v && n < budget) begin
            tick();
            n++;
        end
        check(nm, busy, v);
    endtask

    task automatic pulse_submit(input logic [9:0] a);
        answer = a;
        submit = 1'b1;
        repeat (3) tick();
        submit = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_green"}, green, m_green);
        check({tag, "_red"}, red, m_red);
        check({tag, "_locked"}, locked, m_locked);
    endtask

    // Applies one submit to the model and the DUT. With wait_done=0 returns once DRAW starts.
    task automatic submit_answer(input logic [9:0] a, input bit wait_done);
        int en0;
        bit seen;
        if (!m_locked) begin
            if (a == KEY) begin
                m_green = 1;
                m_red   = 0;
            end else begin
                m_green = 0;
                m_red   = 1;
                if (m_tries < MAX_TRIES) m_tries++;
                if (m_tries == MAX_TRIES) m_locked = 1;
            end
            if (m_locked) push_draw("LOCKED");
            else if (m_green) push_draw("PASS");
            else push_draw("FAIL");
            pulse_submit(a);
            wait_busy(1'b1, 20, "busy_rise");
            if (wait_done) begin
                wait_busy(1'b0, 3000, "busy_fall");
                check("drain", exp_q.size(), 0);
                check_flags("verdict");
            end
        end else begin
            en0  = en_rises;
            seen = 0;
            pulse_submit(a);
            repeat (30) begin
                tick();
                if (busy) seen = 1;
            end
            check("locked_no_busy", seen, 0);
            check("locked_no_en", en_rises - en0, 0);
        end
    endtask

    // Soft clear from the current point; any byte in flight is abandoned.
    task automatic soft_rst();
        ignore_fall = (lcd_en === 1'b1);
        exp_q.delete();
        rst = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        check("rst_en_low", lcd_en, 1'b0);
        check("rst_busy", busy, 1'b1);
        m_tries = 0; m_locked = 0; m_green = 0; m_red = 0;
        check_flags("rst");
        tick();
        rst = 1'b0;
        push_init();
        wait_busy(1'b0, 3000, "reinit_done");
        check("reinit_drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en0;
        bit seen;
        logic [9:0] a;

        // Hard reset state
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_busy", busy, 1'b1);
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        check("rst_data", lcd_data, 8'h00);
        check_flags("por");

        // Release: power-up wait, init commands, READY banner
        push_init();
        tick();
        iRST_N = 1'b1;
        n = 0;
        while (lcd_en !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("pwrup_en_seen", lcd_en, 1'b1);
        check("pwrup_wait_ok", (n >= CLR_DLY + 1), 1'b1);
        wait_busy(1'b0, 3000, "init_done");
        check("init_drain", exp_q.size(), 0);
        check_flags("init");

        // Correct answer
        submit_answer(KEY, 1'b1);

        // Wrong answer with a second submit arriving mid-DRAW (must be dropped)
        submit_answer(10'h001, 1'b0);
        repeat (10) tick();
        pulse_submit(10'h002);
        wait_busy(1'b0, 3000, "drop_busy_fall");
        check("drop_drain", exp_q.size(), 0);
        check_flags("drop");
        seen = 0;
        repeat (20) begin
            tick();
            if (busy) seen = 1;
        end
        check("drop_single_draw", seen, 0);

        // Soft clear while EN is high in DRAW
        submit_answer(10'h001, 1'b0);
        en0 = en_rises;
        n = 0;
        while (!(lcd_en === 1'b1 && en_rises >= en0 + 5) && n < 500) begin
            tick();
            n++;
        end
        check("abort_en_high", lcd_en, 1'b1);
        soft_rst();

        // Lockout after MAX_TRIES wrong answers; the next submit is ignored
        for (int i = 0; i < MAX_TRIES; i++) submit_answer(10'h001, 1'b1);
        submit_answer(10'h001, 1'b1);

        // Randomised answers from a clean start
        soft_rst();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = KEY;
            end else begin
                a = 10'($urandom);
                if (a == KEY) a = a ^ 10'h001;
            end
            submit_answer(a, 1'b1);
        end

        repeat (20) tick();
        check("final_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
